// File: rtl/tx_fifo_pkg.sv
// Purpose: shared types and default widths for the TX packet FIFO controller.
// Contents: write/read FSM state enums, default payload and address widths.
package tx_fifo_pkg;

    localparam int unsigned DEF_DWIDTH = 32;
    localparam int unsigned DEF_AWIDTH = 10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PKT  = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_PKT  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/tx_pkt_fifo_ctrl_if.sv
// Purpose: bundles the host write channel, MAC read channel, packet-memory
//          port and status signals of the TX packet FIFO controller.
// Modports:
//   master - the controller: drives wr_ready, rd_*, mem_w*/mem_raddr,
//            mem_write, pkt_cnt, ovf_drop; samples host/MAC/memory inputs.
//   slave  - the surrounding system: host, MAC and packet memory.
interface tx_pkt_fifo_ctrl_if
    import tx_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = DEF_DWIDTH,
    parameter int unsigned AWIDTH = DEF_AWIDTH
);

    // Host write channel
    logic              wr_valid;
    logic              wr_ready;
    logic [DWIDTH-1:0] wr_data;
    logic              wr_eop;
    logic              wr_abort;

    // MAC read channel
    logic              rd_valid;
    logic              rd_ready;
    logic [DWIDTH-1:0] rd_data;
    logic              rd_eop;

    // Packet memory port, words stored as {eop, data}
    logic [AWIDTH-1:0] mem_waddr;
    logic [AWIDTH-1:0] mem_raddr;
    logic [DWIDTH:0]   mem_wdata;
    logic              mem_write;
    logic [DWIDTH:0]   mem_rdata;

    // Status
    logic [AWIDTH:0]   pkt_cnt;
    logic              ovf_drop;

    modport master (
        input  wr_valid, wr_data, wr_eop, wr_abort,
        output wr_ready,
        output rd_valid, rd_data, rd_eop,
        input  rd_ready,
        output mem_waddr, mem_raddr, mem_wdata, mem_write,
        input  mem_rdata,
        output pkt_cnt, ovf_drop
    );

    modport slave (
        output wr_valid, wr_data, wr_eop, wr_abort,
        input  wr_ready,
        input  rd_valid, rd_data, rd_eop,
        output rd_ready,
        input  mem_waddr, mem_raddr, mem_wdata, mem_write,
        output mem_rdata,
        input  pkt_cnt, ovf_drop
    );

endinterface

// File: rtl/tx_pkt_fifo_ctrl.sv
// Purpose: store-and-forward TX packet FIFO controller over an external
//          packet memory. Words become visible to the MAC only once their
//          packet's eop has been written; aborted or oversize packets are
//          rolled back to the last committed boundary.
// Ports:
//   clk    - sole clock
//   resetn - asynchronous active-low reset
//   bus    - tx_pkt_fifo_ctrl_if.master (host write, MAC read, memory, status)
module tx_pkt_fifo_ctrl
    import tx_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = DEF_DWIDTH,
    parameter int unsigned AWIDTH = DEF_AWIDTH
) (
    input  logic                clk,
    input  logic                resetn,
    tx_pkt_fifo_ctrl_if.master  bus
);

    localparam int unsigned PW    = AWIDTH + 1;
    localparam int unsigned DEPTH = 1 << AWIDTH;

    wr_state_t     wr_state, wr_state_n;
    rd_state_t     rd_state, rd_state_n;

    logic [PW-1:0] wr_ptr, wr_ptr_n;
    logic [PW-1:0] wr_cmt, wr_cmt_n;
    logic [PW-1:0] rd_ptr, rd_ptr_n;
    logic [PW-1:0] pkt_cnt, pkt_cnt_n;

    logic          full;
    logic          empty;
    logic          commit;
    logic          release_pkt;
    logic          rd_fire;
    logic          wr_ready_c;
    logic          mem_write_c;
    logic          ovf_drop_c;

    // Occupancy from registered pointers only, so a same-cycle read never frees a slot
    assign full  = ((wr_ptr - rd_ptr) == PW'(DEPTH));
    assign empty = (rd_ptr == wr_cmt);

    // State and pointer registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
            wr_ptr   <= '0;
            wr_cmt   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
        end else begin
            wr_state <= wr_state_n;
            rd_state <= rd_state_n;
            wr_ptr   <= wr_ptr_n;
            wr_cmt   <= wr_cmt_n;
            rd_ptr   <= rd_ptr_n;
            pkt_cnt  <= pkt_cnt_n;
        end
    end

    // Write FSM: speculative write pointer, commit on eop, rollback on abort/oversize
    always_comb begin
        wr_state_n  = wr_state;
        wr_ptr_n    = wr_ptr;
        wr_cmt_n    = wr_cmt;
        wr_ready_c  = 1'b0;
        mem_write_c = 1'b0;
        ovf_drop_c  = 1'b0;
        commit      = 1'b0;
        case (wr_state)
            W_IDLE, W_PKT: begin
                wr_ready_c = !full && !bus.wr_abort;
                if ((wr_state == W_PKT) && bus.wr_abort) begin
                    wr_ptr_n   = wr_cmt;
                    wr_state_n = W_IDLE;
                end else if ((wr_state == W_PKT) && full && (pkt_cnt == '0)) begin
                    // Packet fills the whole memory with nothing to drain: it can never fit
                    wr_ptr_n   = wr_cmt;
                    wr_state_n = W_DROP;
                end else if (bus.wr_valid && wr_ready_c) begin
                    mem_write_c = 1'b1;
                    wr_ptr_n    = wr_ptr + PW'(1);
                    if (bus.wr_eop) begin
                        commit     = 1'b1;
                        wr_cmt_n   = wr_ptr + PW'(1);
                        wr_state_n = W_IDLE;
                    end else begin
                        wr_state_n = W_PKT;
                    end
                end
            end
            W_DROP: begin
                // Swallow the rest of the oversize packet without storing it
                wr_ready_c = 1'b1;
                if (bus.wr_abort || (bus.wr_valid && bus.wr_eop)) begin
                    ovf_drop_c = 1'b1;
                    wr_state_n = W_IDLE;
                end
            end
            default: begin
                wr_state_n = W_IDLE;
            end
        endcase
    end

    // Read FSM: present committed words straight from memory
    always_comb begin
        rd_state_n  = rd_state;
        rd_ptr_n    = rd_ptr;
        release_pkt = 1'b0;
        rd_fire     = !empty && bus.rd_ready;
        if (rd_fire) begin
            rd_ptr_n = rd_ptr + PW'(1);
            if (bus.mem_rdata[DWIDTH]) begin
                release_pkt = 1'b1;
                rd_state_n  = R_IDLE;
            end else begin
                rd_state_n  = R_PKT;
            end
        end
    end

    // Packet count: simultaneous commit and release cancel out
    always_comb begin
        pkt_cnt_n = pkt_cnt;
        case ({commit, release_pkt})
            2'b10:   pkt_cnt_n = pkt_cnt + PW'(1);
            2'b01:   pkt_cnt_n = pkt_cnt - PW'(1);
            default: pkt_cnt_n = pkt_cnt;
        endcase
    end

    assign bus.wr_ready  = wr_ready_c;
    assign bus.mem_write = mem_write_c;
    assign bus.mem_waddr = wr_ptr[AWIDTH-1:0];
    assign bus.mem_wdata = {bus.wr_eop, bus.wr_data};
    assign bus.mem_raddr = rd_ptr[AWIDTH-1:0];
    assign bus.rd_valid  = !empty;
    assign bus.rd_data   = bus.mem_rdata[DWIDTH-1:0];
    assign bus.rd_eop    = bus.mem_rdata[DWIDTH];
    assign bus.pkt_cnt   = pkt_cnt;
    assign bus.ovf_drop  = ovf_drop_c;

endmodule

// File: tb/tb_tx_pkt_fifo_ctrl.sv
// Purpose: scoreboard testbench for tx_pkt_fifo_ctrl (AWIDTH=4, DWIDTH=32)
//          with a behavioural packet memory.
module tb_tx_pkt_fifo_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;

    logic clk;
    logic resetn;

    tx_pkt_fifo_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    tx_pkt_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet memory model: synchronous write, combinational read
    logic [DW:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_waddr] <= bus.mem_wdata;
    assign bus.mem_rdata = mem[bus.mem_raddr];

    int n_cmp = 0;
    int n_err = 0;
    logic [DW:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every MAC read handshake is checked against the scoreboard
    always @(negedge clk) begin
        if (resetn && bus.rd_valid && bus.rd_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got %0h expected no word at %0t",
                         {bus.rd_eop, bus.rd_data}, $time);
            end else begin
                chk("rd_word", 64'({bus.rd_eop, bus.rd_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic e);
        exp_q.push_back({e, d});
    endtask

    // Present one word and hold it until accepted (bounded)
    task automatic put(input logic [DW-1:0] d, input logic e,
                       output int stall, output logic mw, output logic ov);
        stall = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_eop   = e;
        @(negedge clk);
        while (!bus.wr_ready && stall < 40) begin
            @(negedge clk);
            stall++;
        end
        if (!bus.wr_ready) chk("put_timeout", 64'(stall), 64'(0));
        mw = bus.mem_write;
        ov = bus.ovf_drop;
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        bus.wr_eop   = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        resetn = 1'b0;
        exp_q.delete();
        step();
        resetn = 1'b1;
    endtask

    int   st;
    logic mw;
    logic ov;

    initial begin
        resetn       = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_eop   = 1'b0;
        bus.wr_abort = 1'b0;
        bus.rd_ready = 1'b0;

        // Reset values
        #12;
        chk("rst_wr_ready", 64'(bus.wr_ready), 64'(1));
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
        chk("rst_mem_write", 64'(bus.mem_write), 64'(0));
        chk("rst_ovf_drop", 64'(bus.ovf_drop), 64'(0));
        chk("rst_addrs", 64'({bus.mem_waddr, bus.mem_raddr}), 64'(0));
        chk("rst_pkt_cnt", 64'(bus.pkt_cnt), 64'(0));
        step();
        resetn = 1'b1;

        // 3-word packet with the MAC always ready
        bus.rd_ready = 1'b1;
        put(32'hA1, 1'b0, st, mw, ov);
        put(32'hA2, 1'b0, st, mw, ov);
        chk("a_no_early_valid", 64'(bus.rd_valid), 64'(0));
        chk("a_cnt_before", 64'(bus.pkt_cnt), 64'(0));
        push(32'hA1, 1'b0); push(32'hA2, 1'b0); push(32'hA3, 1'b1);
        put(32'hA3, 1'b1, st, mw, ov);
        chk("a_valid_after_eop", 64'(bus.rd_valid), 64'(1));
        chk("a_cnt_commit", 64'(bus.pkt_cnt), 64'(1));
        step(); step(); step();
        chk("a_cnt_drained", 64'(bus.pkt_cnt), 64'(0));
        chk("a_empty", 64'(bus.rd_valid), 64'(0));

        // Abort a partial packet, then send a fresh one
        do_reset();
        put(32'hB1, 1'b0, st, mw, ov);
        put(32'hB2, 1'b0, st, mw, ov);
        bus.wr_abort = 1'b1;
        @(negedge clk);
        chk("abort_blocks_ready", 64'(bus.wr_ready), 64'(0));
        step();
        bus.wr_abort = 1'b0;
        chk("abort_waddr", 64'(bus.mem_waddr), 64'(0));
        chk("abort_no_valid", 64'(bus.rd_valid), 64'(0));
        push(32'hC1, 1'b0); push(32'hC2, 1'b1);
        put(32'hC1, 1'b0, st, mw, ov);
        put(32'hC2, 1'b1, st, mw, ov);
        chk("c_valid", 64'(bus.rd_valid), 64'(1));
        chk("c_raddr", 64'(bus.mem_raddr), 64'(0));
        step(); step();

        // Read eop of D in the same cycle E commits
        bus.rd_ready = 1'b0;
        push(32'hD1, 1'b0); push(32'hD2, 1'b1);
        put(32'hD1, 1'b0, st, mw, ov);
        put(32'hD2, 1'b1, st, mw, ov);
        chk("d_cnt", 64'(bus.pkt_cnt), 64'(1));
        put(32'hE1, 1'b0, st, mw, ov);
        bus.rd_ready = 1'b1;
        put(32'hE2, 1'b0, st, mw, ov);
        push(32'hE1, 1'b0); push(32'hE2, 1'b0); push(32'hE3, 1'b1);
        put(32'hE3, 1'b1, st, mw, ov);
        chk("commit_and_release", 64'(bus.pkt_cnt), 64'(1));
        step(); step(); step();
        chk("e_drained", 64'(bus.pkt_cnt), 64'(0));

        // Fill to full with two 8-word packets
        do_reset();
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(32'h100 + 32'(i), (i % 8) == 7);
            put(32'h100 + 32'(i), (i % 8) == 7, st, mw, ov);
        end
        chk("full_cnt", 64'(bus.pkt_cnt), 64'(2));
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h1F0;
        bus.wr_eop   = 1'b0;
        bus.rd_ready = 1'b1;
        @(negedge clk);
        chk("full_refuse_same_cycle", 64'(bus.wr_ready), 64'(0));
        step();
        bus.rd_ready = 1'b0;
        @(negedge clk);
        chk("slot_freed", 64'(bus.wr_ready), 64'(1));
        step();
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("full_again", 64'(bus.wr_ready), 64'(0));
        step();
        bus.wr_abort = 1'b1;
        step();
        bus.wr_abort = 1'b0;
        chk("full_abort_waddr", 64'(bus.mem_waddr), 64'(0));
        bus.rd_ready = 1'b1;
        repeat (15) step();
        chk("full_drained_cnt", 64'(bus.pkt_cnt), 64'(0));
        chk("full_drained_valid", 64'(bus.rd_valid), 64'(0));

        // 20-word oversize packet
        do_reset();
        bus.rd_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            put(32'h200 + 32'(i), i == 20, st, mw, ov);
            if (i == 16) chk("ovs_w16_written", 64'(mw), 64'(1));
            if (i == 17) chk("ovs_drop_entry_stall", 64'(st), 64'(1));
            if (i >= 17) chk("ovs_no_write", 64'(mw), 64'(0));
            if (i == 19) chk("ovs_no_early_pulse", 64'(ov), 64'(0));
            if (i == 20) chk("ovs_pulse", 64'(ov), 64'(1));
        end
        chk("ovs_pulse_done", 64'(bus.ovf_drop), 64'(0));
        chk("ovs_cnt", 64'(bus.pkt_cnt), 64'(0));
        chk("ovs_waddr", 64'(bus.mem_waddr), 64'(0));
        bus.rd_ready = 1'b1;
        step();
        chk("ovs_no_read", 64'(bus.rd_valid), 64'(0));

        // Reset in the middle of a read
        bus.rd_ready = 1'b0;
        push(32'hF1, 1'b0); push(32'hF2, 1'b0); push(32'hF3, 1'b1);
        put(32'hF1, 1'b0, st, mw, ov);
        put(32'hF2, 1'b0, st, mw, ov);
        put(32'hF3, 1'b1, st, mw, ov);
        bus.rd_ready = 1'b1;
        step();
        chk("mid_raddr", 64'(bus.mem_raddr), 64'(1));
        #1;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rd_valid", 64'(bus.rd_valid), 64'(0));
        chk("async_raddr", 64'(bus.mem_raddr), 64'(0));
        chk("async_waddr", 64'(bus.mem_waddr), 64'(0));
        chk("async_cnt", 64'(bus.pkt_cnt), 64'(0));
        chk("async_wr_ready", 64'(bus.wr_ready), 64'(1));
        step();
        resetn = 1'b1;
        push(32'h61, 1'b0); push(32'h62, 1'b1);
        put(32'h61, 1'b0, st, mw, ov);
        put(32'h62, 1'b1, st, mw, ov);
        chk("post_rst_raddr", 64'(bus.mem_raddr), 64'(0));
        chk("post_rst_valid", 64'(bus.rd_valid), 64'(1));
        step(); step();
        chk("post_rst_cnt", 64'(bus.pkt_cnt), 64'(0));

        // All expected words must have been read
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
